saturn_cycle_sequencer: RTL and testbench

//  Generates the 4-phase clock sequence and cycle counter that drive the Saturn core and the

---
 rtl/saturn_cycle_sequencer.sv | 165 ++++++++++++++++
 tb/tb_saturn_cycle_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/saturn_cycle_sequencer.sv
// saturn_cycle_sequencer
//   Generates the 4-phase clock sequence and instruction-cycle counter for the
//   Saturn core and debugger. It also schedules core and debug cycles: the core
//   is frozen only on instruction-cycle boundaries, for debug cycles,
//   breakpoints, halt, single-step and resume.
// Ports
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_dbg_req         debugger requests a debug cycle (level, held until granted)
//   i_dbg_done        debugger finished the current debug cycle (1-clock pulse)
//   i_halt            halt at the next cycle boundary (level)
//   i_run / i_step    resume / single-step from HALT (pulses)
//   i_break_en        enable the cycle-count breakpoint
//   i_break_cycle     cycle count at which to halt
//   o_phases          one-hot current phase
//   o_phase           current phase index
//   o_cycle_ctr       completed instruction-cycle count
//   o_core_en         core may advance this clock
//   o_debug_cycle     debugger owns the core
//   o_halted          sequencer is in HALT
//   o_dbg_timeout     1-clock pulse: debug cycle aborted by timeout
module saturn_cycle_sequencer #(
    parameter int unsigned CTR_WIDTH     = 32,
    parameter int unsigned DBG_TIMEOUT   = 255,
    parameter int unsigned HALT_ON_RESET = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_dbg_req,
    input  logic                 i_dbg_done,
    input  logic                 i_halt,
    input  logic                 i_run,
    input  logic                 i_step,
    input  logic                 i_break_en,
    input  logic [CTR_WIDTH-1:0] i_break_cycle,
    output logic [3:0]           o_phases,
    output logic [1:0]           o_phase,
    output logic [CTR_WIDTH-1:0] o_cycle_ctr,
    output logic                 o_core_en,
    output logic                 o_debug_cycle,
    output logic                 o_halted,
    output logic                 o_dbg_timeout
);

    localparam int unsigned TMO_W  = (DBG_TIMEOUT < 2) ? 1 : $clog2(DBG_TIMEOUT + 1);
    localparam int unsigned TMO_W1 = TMO_W + 1;

    typedef enum logic [1:0] {S_RUN, S_DEBUG, S_HALT, S_STEP} state_t;

    localparam state_t RESET_STATE = (HALT_ON_RESET != 0) ? S_HALT : S_RUN;

    state_t             state_q, state_d;
    logic               ret_q, ret_d;          // 1: return to HALT after DEBUG, 0: to RUN
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [1:0]         phase_d;
    logic [3:0]         phases_d;
    logic [CTR_WIDTH-1:0] ctr_d;
    logic               core_en_d, debug_d, halted_d, tmo_pulse_d;

    logic                 core_run_c;
    logic                 boundary_c;
    logic [CTR_WIDTH-1:0] ctr_inc_c;
    logic                 bp_hit_c;
    logic                 tmo_hit_c;
    state_t               ret_state_c;

    // Shared decodes of the current registered state
    assign core_run_c  = (state_q == S_RUN) || (state_q == S_STEP);
    assign boundary_c  = core_run_c && (o_phase == 2'd3);
    assign ctr_inc_c   = o_cycle_ctr + CTR_WIDTH'(1);
    assign bp_hit_c    = i_break_en && (ctr_inc_c == i_break_cycle);
    // Hit on the clock that completes DBG_TIMEOUT clocks in DEBUG (counter starts at 0)
    assign tmo_hit_c   = (DBG_TIMEOUT != 0) &&
                         (({1'b0, tmo_cnt_q} + TMO_W1'(1)) == TMO_W1'(DBG_TIMEOUT));
    assign ret_state_c = ret_q ? S_HALT : S_RUN;

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= RESET_STATE;
            ret_q         <= 1'b0;
            tmo_cnt_q     <= '0;
            o_phase       <= 2'd0;
            o_phases      <= 4'b0001;
            o_cycle_ctr   <= '0;
            o_core_en     <= (HALT_ON_RESET == 0);
            o_debug_cycle <= 1'b0;
            o_halted      <= (HALT_ON_RESET != 0);
            o_dbg_timeout <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            tmo_cnt_q     <= tmo_cnt_d;
            o_phase       <= phase_d;
            o_phases      <= phases_d;
            o_cycle_ctr   <= ctr_d;
            o_core_en     <= core_en_d;
            o_debug_cycle <= debug_d;
            o_halted      <= halted_d;
            o_dbg_timeout <= tmo_pulse_d;
        end
    end

    // Next-state logic; RUN and STEP only change state on a cycle boundary
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            S_RUN: begin
                if (boundary_c) begin
                    if (i_dbg_req) begin
                        state_d = S_DEBUG;
                        ret_d   = 1'b0;
                    end else if (bp_hit_c || i_halt) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_DEBUG: begin
                if (i_dbg_done || tmo_hit_c) begin
                    state_d = ret_state_c;
                end
            end
            S_HALT: begin
                if (i_dbg_req) begin
                    state_d = S_DEBUG;
                    ret_d   = 1'b1;
                end else if (i_step) begin
                    state_d = S_STEP;
                end else if (i_run) begin
                    state_d = S_RUN;
                end
            end
            S_STEP: begin
                if (boundary_c) begin
                    state_d = i_dbg_req ? S_DEBUG : S_HALT;
                    ret_d   = i_dbg_req ? 1'b1 : ret_q;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // Output / datapath next values, registered by the state register
    always_comb begin
        phase_d     = o_phase;
        ctr_d       = o_cycle_ctr;
        tmo_cnt_d   = '0;
        if (core_run_c) begin
            phase_d = o_phase + 2'd1;
            if (o_phase == 2'd3) begin
                ctr_d = ctr_inc_c;
            end
        end
        if (state_q == S_DEBUG) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        phases_d    = 4'b0001 << phase_d;
        core_en_d   = (state_d == S_RUN) || (state_d == S_STEP);
        debug_d     = (state_d == S_DEBUG);
        halted_d    = (state_d == S_HALT);
        // A done on the timeout clock wins and suppresses the pulse
        tmo_pulse_d = (state_q == S_DEBUG) && !i_dbg_done && tmo_hit_c;
    end

endmodule

// File: tb/tb_saturn_cycle_sequencer.sv
module tb_saturn_cycle_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // DUT A: default parameters; DUT C: same stimulus, HALT_ON_RESET=1
    logic        a_rst, a_dbg_req, a_dbg_done, a_halt, a_run, a_step, a_break_en;
    logic [31:0] a_break_cycle;
    logic [3:0]  a_phases, c_phases;
    logic [1:0]  a_phase, c_phase;
    logic [31:0] a_ctr, c_ctr;
    logic        a_core_en, a_dbg, a_halted, a_tmo;
    logic        c_core_en, c_dbg, c_halted, c_tmo;

    // DUT B: CTR_WIDTH=4, DBG_TIMEOUT=4
    logic        b_rst, b_dbg_req, b_dbg_done, b_halt, b_run, b_step, b_break_en;
    logic [3:0]  b_break_cycle;
    logic [3:0]  b_phases;
    logic [1:0]  b_phase;
    logic [3:0]  b_ctr;
    logic        b_core_en, b_dbg, b_halted, b_tmo;

    saturn_cycle_sequencer u_a (
        .i_clk(clk), .i_reset_n(a_rst), .i_dbg_req(a_dbg_req), .i_dbg_done(a_dbg_done),
        .i_halt(a_halt), .i_run(a_run), .i_step(a_step), .i_break_en(a_break_en),
        .i_break_cycle(a_break_cycle), .o_phases(a_phases), .o_phase(a_phase),
        .o_cycle_ctr(a_ctr), .o_core_en(a_core_en), .o_debug_cycle(a_dbg),
        .o_halted(a_halted), .o_dbg_timeout(a_tmo)
    );

    saturn_cycle_sequencer #(.HALT_ON_RESET(1)) u_c (
        .i_clk(clk), .i_reset_n(a_rst), .i_dbg_req(a_dbg_req), .i_dbg_done(a_dbg_done),
        .i_halt(a_halt), .i_run(a_run), .i_step(a_step), .i_break_en(a_break_en),
        .i_break_cycle(a_break_cycle), .o_phases(c_phases), .o_phase(c_phase),
        .o_cycle_ctr(c_ctr), .o_core_en(c_core_en), .o_debug_cycle(c_dbg),
        .o_halted(c_halted), .o_dbg_timeout(c_tmo)
    );

    saturn_cycle_sequencer #(.CTR_WIDTH(4), .DBG_TIMEOUT(4)) u_b (
        .i_clk(clk), .i_reset_n(b_rst), .i_dbg_req(b_dbg_req), .i_dbg_done(b_dbg_done),
        .i_halt(b_halt), .i_run(b_run), .i_step(b_step), .i_break_en(b_break_en),
        .i_break_cycle(b_break_cycle), .o_phases(b_phases), .o_phase(b_phase),
        .o_cycle_ctr(b_ctr), .o_core_en(b_core_en), .o_debug_cycle(b_dbg),
        .o_halted(b_halted), .o_dbg_timeout(b_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] phases, input logic [31:0] ctr,
                         input logic core_en, input logic dbg, input logic halted, input logic tmo);
        chk({tag, ".phases"}, 32'(a_phases), 32'(phases));
        chk({tag, ".ctr"}, a_ctr, ctr);
        chk({tag, ".core_en"}, 32'(a_core_en), 32'(core_en));
        chk({tag, ".dbg"}, 32'(a_dbg), 32'(dbg));
        chk({tag, ".halted"}, 32'(a_halted), 32'(halted));
        chk({tag, ".tmo"}, 32'(a_tmo), 32'(tmo));
    endtask

    task automatic chk_c_reset(input string tag);
        chk({tag, ".c_phases"}, 32'(c_phases), 32'h1);
        chk({tag, ".c_ctr"}, c_ctr, 32'h0);
        chk({tag, ".c_core_en"}, 32'(c_core_en), 32'h0);
        chk({tag, ".c_dbg"}, 32'(c_dbg), 32'h0);
        chk({tag, ".c_halted"}, 32'(c_halted), 32'h1);
    endtask

    task automatic chk_b(input string tag, input logic [3:0] phases, input logic [3:0] ctr,
                         input logic core_en, input logic dbg, input logic halted, input logic tmo);
        chk({tag, ".phases"}, 32'(b_phases), 32'(phases));
        chk({tag, ".ctr"}, 32'(b_ctr), 32'(ctr));
        chk({tag, ".core_en"}, 32'(b_core_en), 32'(core_en));
        chk({tag, ".dbg"}, 32'(b_dbg), 32'(dbg));
        chk({tag, ".halted"}, 32'(b_halted), 32'(halted));
        chk({tag, ".tmo"}, 32'(b_tmo), 32'(tmo));
    endtask

    initial begin
        a_rst = 1'b1; a_dbg_req = 0; a_dbg_done = 0; a_halt = 0; a_run = 0; a_step = 0;
        a_break_en = 0; a_break_cycle = '0;
        b_rst = 1'b1; b_dbg_req = 0; b_dbg_done = 0; b_halt = 0; b_run = 0; b_step = 0;
        b_break_en = 0; b_break_cycle = '0;
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;
        // Reset values
        chk_a("rst", 4'b0001, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_c_reset("rst");
        chk("rst.phase", 32'(a_phase), 32'd0);
        tick(2);
        a_rst = 1'b1;

        // 1: free run, phases 1,2,4,8,1,2,4,8
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("run.phases%0d", i), 32'(a_phases), 32'(4'b0001 << (i % 4)));
            chk($sformatf("run.core_en%0d", i), 32'(a_core_en), 32'd1);
            if (i == 0) begin
                chk("haltrst.c_halted", 32'(c_halted), 32'd1);
            end
            tick();
        end
        chk_a("run8", 4'b0001, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("run8.c_halted", 32'(c_halted), 32'd1);
        chk("run8.c_core_en", 32'(c_core_en), 32'd0);
        chk("run8.c_phases", 32'(c_phases), 32'h1);

        // 2: debug request mid-cycle waits for boundary
        tick();
        a_dbg_req = 1'b1;
        tick();
        chk_a("dreq.ph2", 4'b0100, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_a("dreq.ph3", 4'b1000, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_a("dbg.entry", 4'b0001, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        a_dbg_req = 1'b0;
        tick(4);
        chk_a("dbg.clk5", 4'b0001, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        a_dbg_done = 1'b1;
        tick();
        a_dbg_done = 1'b0;
        chk_a("dbg.exit", 4'b0001, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_a("dbg.resume", 4'b0010, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        // i_run / i_step outside HALT are ignored
        a_run = 1'b1; a_step = 1'b1;
        tick();
        a_run = 1'b0; a_step = 1'b0;
        chk_a("run.ignored", 4'b0100, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        // 3: breakpoint at cycle 3 from reset, then step and run
        a_rst = 1'b0;
        a_break_en = 1'b1;
        a_break_cycle = 32'd3;
        tick();
        a_rst = 1'b1;
        tick(11);
        chk_a("bp.11", 4'b1000, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_a("bp.hit", 4'b0001, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        a_halt = 1'b1;
        tick();
        a_halt = 1'b0;
        chk_a("halt.hold", 4'b0001, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        a_step = 1'b1;
        tick();
        a_step = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_a($sformatf("step%0d", i), 4'(4'b0001 << i), 32'd3, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk_a("step.done", 4'b0001, 32'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        a_run = 1'b1;
        tick();
        a_run = 1'b0;
        a_break_en = 1'b0;
        chk_a("resume", 4'b0001, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0);

        // 6a: reset asserted between edges in DEBUG
        a_dbg_req = 1'b1;
        tick(4);
        chk_a("dbg2.entry", 4'b0001, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        a_dbg_req = 1'b0;
        #3;
        a_rst = 1'b0;
        #1;
        chk_a("rst.dbg", 4'b0001, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_c_reset("rst.dbg");
        tick();
        a_rst = 1'b1;

        // 6b: reset asserted between edges in STEP
        a_halt = 1'b1;
        tick(4);
        a_halt = 1'b0;
        chk_a("halt.req", 4'b0001, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        a_step = 1'b1;
        tick();
        a_step = 1'b0;
        tick();
        chk_a("step2.ph1", 4'b0010, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        a_rst = 1'b0;
        #1;
        chk_a("rst.step", 4'b0001, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_c_reset("rst.step");

        // 4: debug timeout on DUT B
        tick();
        b_rst = 1'b1;
        b_dbg_req = 1'b1;
        tick(4);
        b_dbg_req = 1'b0;
        chk_b("tmo.c1", 4'b0001, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(3);
        chk_b("tmo.c4", 4'b0001, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_b("tmo.exit", 4'b0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_b("tmo.pulse_end", 4'b0010, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        b_dbg_req = 1'b1;
        tick(3);
        b_dbg_req = 1'b0;
        chk_b("done.c1", 4'b0001, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(3);
        b_dbg_done = 1'b1;
        tick();
        b_dbg_done = 1'b0;
        chk_b("done.exit", 4'b0001, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_b("done.after", 4'b0010, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);

        // 5: 4-bit counter wrap, then breakpoint at 0
        b_rst = 1'b0;
        tick();
        b_rst = 1'b1;
        tick(60);
        chk_b("wrap.15", 4'b0001, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4);
        chk_b("wrap.0", 4'b0001, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        b_break_en = 1'b1;
        b_break_cycle = 4'd0;
        tick(63);
        chk_b("bpwrap.63", 4'b1000, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_b("bpwrap.hit", 4'b0001, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
